fifo_rd_streamer: RTL and testbench

- Read-side consumer for the team's 8-bit asynchronous FIFO. Runs entirely in the FIFO read clock domain.
- Pulls bytes through the FIFO read port (rd/empty/d_out, one-cycle read latency) and presents them downstream as a valid/ready byte stream with packet framing.
- Counterpart of the FIFO write-side producer; converts FIFO pop semantics into a back-pressurable stream without losing or duplicating bytes.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_skid_buf.sv | 77 +++++++
 rtl/fifo_rd_streamer.sv | 87 ++++++++
 tb/tb_fifo_rd_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fifo_pkg                                              |
// | Purpose  : Shared widths for the 8-bit async FIFO and its peers. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package fifo_pkg;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 1 << ADDR_W;
endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fifo_skid_buf                                         |
// | Purpose  : Small circular buffer with push/pop, occupancy, head. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int DW    = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic [DW-1:0]              head_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL     = OCC_W'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    assign do_pop = pop_i & (cnt_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push_i) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
        end
        if (push_i && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[head_q];

    // The read-issue throttle upstream must keep a full buffer from ever seeing a lone push.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push_i && !do_pop && (cnt_q == FULL)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fifo_rd_streamer                                      |
// | Purpose  : Turns FIFO pops into a framed valid/ready byte stream.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int BUF_DEPTH = 3,
    parameter int PKT_LEN   = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_d,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              busy
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [OCC_W:0]   DEPTH_L  = (OCC_W + 1)'(BUF_DEPTH);

    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    committed;
    logic              beat;

    fifo_skid_buf #(
        .DEPTH (BUF_DEPTH),
        .DW    (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pend_q),
        .push_data_i (fifo_d),
        .pop_i       (beat),
        .cnt_o       (occ),
        .head_o      (m_data)
    );

    // Counting the in-flight byte as occupied guarantees it always has a slot to land in.
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, pend_q};
    assign fifo_rd   = rst & en & ~fifo_empty & (committed < DEPTH_L);

    assign m_valid = (occ != '0);
    assign m_last  = m_valid & (idx_q == LAST_IDX);
    assign beat    = m_valid & m_ready;
    assign busy    = pend_q | (occ != '0);
    assign pkt_cnt = pkt_cnt_q;

    always_comb begin
        pend_d    = fifo_rd & ~fifo_empty;
        idx_d     = idx_q;
        pkt_cnt_d = pkt_cnt_q;
        if (beat) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (m_last) begin
                pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= 1'b0;
            idx_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fifo_rd_streamer                                   |
// | Purpose  : Directed self-checking bench for fifo_rd_streamer.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_fifo_rd_streamer;
    logic        clk;
    logic        rst;
    logic        en, m_ready;
    logic        fifo_empty, fifo_rd;
    logic [7:0]  fifo_d;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy;
    logic [15:0] pkt_cnt;

    logic        en2, m_ready2;
    logic        fifo_empty2, fifo_rd2;
    logic [7:0]  fifo_d2, m_data2;
    logic        m_valid2, m_last2, busy2;
    logic [7:0]  pkt_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_rd_streamer #(.BUF_DEPTH(3), .PKT_LEN(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_d(fifo_d), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    fifo_rd_streamer #(.BUF_DEPTH(3), .PKT_LEN(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2), .fifo_rd(fifo_rd2),
        .fifo_d(fifo_d2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .m_last(m_last2), .pkt_cnt(pkt_cnt2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, flushed by the shared reset.
    logic [7:0] fmem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_d <= fmem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int f2_total = 0;
    int f2_taken = 0;
    assign fifo_empty2 = (f2_taken >= f2_total);
    always @(posedge clk) begin
        if (rst && fifo_rd2 && !fifo_empty2) begin
            fifo_d2  <= f2_taken[7:0];
            f2_taken <= f2_taken + 1;
        end
    end

    // Beat capture and committed-occupancy model (buffer + in-flight byte).
    logic [8:0] beats [$];
    int bh   = 0;
    int occ  = 0;
    int viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            occ  <= 0;
            viol <= 0;
        end else begin
            if (fifo_rd && occ >= 3) viol <= viol + 1;
            occ <= occ + ((fifo_rd && !fifo_empty) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
        end
    end

    int beats2 = 0;
    int lasts2 = 0;
    int derr2  = 0;
    always @(negedge clk) begin
        if (rst && m_valid2 && m_ready2) begin
            beats2 <= beats2 + 1;
            if (m_last2) lasts2 <= lasts2 + 1;
            if (m_data2 !== beats2[7:0]) derr2 <= derr2 + 1;
        end
    end

    int exp_idx  = 0;
    int exp_pkts = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr] = first + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic check_beats(input string tag, input logic [7:0] first, input int n);
        int avail;
        logic [7:0] e;
        avail = beats.size() - bh;
        check({tag, " count"}, avail, n);
        for (int k = 0; k < n && k < avail; k++) begin
            e = first + 8'(k);
            check({tag, " data"}, {24'd0, beats[bh+k][7:0]}, {24'd0, e});
            check({tag, " last"}, {31'd0, beats[bh+k][8]}, {31'd0, exp_idx == 15});
            if (exp_idx == 15) exp_pkts++;
            exp_idx = (exp_idx + 1) % 16;
        end
        bh = beats.size();
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; m_ready = 1'b0; en2 = 1'b0; m_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst fifo_rd", {31'd0, fifo_rd}, 0);
        check("rst m_valid", {31'd0, m_valid}, 0);
        check("rst m_data", {24'd0, m_data}, 0);
        check("rst m_last", {31'd0, m_last}, 0);
        check("rst pkt_cnt", {16'd0, pkt_cnt}, 0);
        check("rst busy", {31'd0, busy}, 0);

        step_in(); rst = 1'b1; push_bytes(8'h00, 16);
        @(negedge clk);
        check("en0 no read", {31'd0, fifo_rd}, 0);

        // Full-rate packet: first beat two cycles after the first read.
        step_in(); en = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        check("t1 c0 fifo_rd", {31'd0, fifo_rd}, 1);
        check("t1 c0 m_valid", {31'd0, m_valid}, 0);
        @(negedge clk);
        check("t1 c1 m_valid", {31'd0, m_valid}, 0);
        check("t1 c1 busy", {31'd0, busy}, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t1 stream valid", {31'd0, m_valid}, 1);
            check("t1 stream data", {24'd0, m_data}, i);
            check("t1 stream last", {31'd0, m_last}, (i == 15) ? 1 : 0);
        end
        repeat (3) @(negedge clk);
        check_beats("t1", 8'h00, 16);
        check("t1 pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);
        check("t1 busy idle", {31'd0, busy}, 0);

        // Back-pressure pattern 1,0,0,1.
        step_in(); push_bytes(8'h00, 16);
        for (int k = 0; k < 64; k++) begin
            m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            step_in();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check_beats("t2", 8'h00, 16);
        check("t2 pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);
        check("t2 no read when full", viol, 0);

        // Stalled sink: only BUF_DEPTH bytes leave the FIFO.
        step_in(); m_ready = 1'b0; push_bytes(8'h20, 10);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3 fifo_rd stalled", {31'd0, fifo_rd}, 0);
        check("t3 m_valid", {31'd0, m_valid}, 1);
        check("t3 head data", {24'd0, m_data}, 32'h20);
        check("t3 fifo left", wr_ptr - rd_ptr, 7);
        step_in(); m_ready = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check_beats("t3", 8'h20, 10);
        check("t3 no read when full", viol, 0);

        // en dropped after five reads.
        step_in(); en = 1'b0; push_bytes(8'h00, 16);
        step_in(); en = 1'b1;
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t4 busy drained", {31'd0, busy}, 0);
        check("t4 fifo left", wr_ptr - rd_ptr, 11);
        check("t4 fifo_rd off", {31'd0, fifo_rd}, 0);
        check_beats("t4a", 8'h00, 5);
        step_in(); en = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_beats("t4b", 8'h05, 11);
        check("t4 pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);

        // Reach idx 7 with two bytes buffered, then reset asynchronously.
        step_in(); push_bytes(8'h30, 13);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_beats("t5 pre", 8'h30, 13);
        step_in(); m_ready = 1'b0; push_bytes(8'h40, 2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5 buffered valid", {31'd0, m_valid}, 1);
        check("t5 buffered data", {24'd0, m_data}, 32'h40);
        step_in(); rst = 1'b0;
        #1;
        check("t5 async m_valid", {31'd0, m_valid}, 0);
        check("t5 async m_data", {24'd0, m_data}, 0);
        check("t5 async m_last", {31'd0, m_last}, 0);
        check("t5 async pkt_cnt", {16'd0, pkt_cnt}, 0);
        check("t5 async busy", {31'd0, busy}, 0);
        check("t5 async fifo_rd", {31'd0, fifo_rd}, 0);
        exp_idx = 0; exp_pkts = 0; bh = beats.size();
        step_in(); rst = 1'b1; m_ready = 1'b1; push_bytes(8'h50, 16);
        repeat (25) @(posedge clk);
        @(negedge clk);
        check_beats("t5 post", 8'h50, 16);
        check("t5 pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);

        // PKT_LEN=1, CNT_W=8: every beat is last, counter wraps.
        step_in(); f2_total = 300; en2 = 1'b1; m_ready2 = 1'b1;
        repeat (310) @(posedge clk);
        @(negedge clk);
        check("t6 beats", beats2, 300);
        check("t6 lasts", lasts2, 300);
        check("t6 data order", derr2, 0);
        check("t6 pkt_cnt wrap", {24'd0, pkt_cnt2}, 44);
        check("t6 busy", {31'd0, busy2}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
